// File: rtl/loader_sdram_write_bridge.sv
// loader_sdram_write_bridge: FIFO-buffered loader byte writes issued one per SDRAM slot (slot_en).
// Optional LOADER_BRIDGE_CHECKSUM_EN adds a running 16-bit sum of issued data bytes.
module loader_sdram_write_bridge #(
    parameter int DEPTH_LOG2 = 3,
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_strobe,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  slot_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_data,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
`ifdef LOADER_BRIDGE_CHECKSUM_EN
    output logic [15:0]           checksum,
`endif
    output logic [7:0]            drop_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                     state_q;
    logic [ADDR_W+DATA_W-1:0]   fifo_q [DEPTH];
    logic [DEPTH_LOG2-1:0]      wptr_q, rptr_q;
    logic [DEPTH_LOG2:0]        level_q, level_d;
    logic                       mem_we_q, overflow_q;
    logic [ADDR_W-1:0]          mem_addr_q;
    logic [DATA_W-1:0]          mem_data_q;
    logic [7:0]                 drop_count_q;
    logic                       full, pop, push, drop;

    // Pop looks at the registered level, so a push landing in the same slot waits one slot.
    assign full    = level_q == (DEPTH_LOG2+1)'(DEPTH);
    assign pop     = slot_en && level_q != '0;
    assign push    = wr_strobe && (!full || pop);
    assign drop    = wr_strobe && !push;
    assign level_d = level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
    assign busy       = level_q != '0 || mem_we_q;

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= {wr_addr, wr_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wptr_q       <= wptr_q + DEPTH_LOG2'(push);
            rptr_q       <= rptr_q + DEPTH_LOG2'(pop);
            level_q      <= level_d;
            overflow_q   <= overflow_q | drop;
            drop_count_q <= (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
        end
    end

    // Both states pop whenever data is waiting, which keeps mem_we high across back-to-back slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else if (slot_en) begin
            if (pop) begin
                {mem_addr_q, mem_data_q} <= fifo_q[rptr_q];
                mem_we_q                 <= 1'b1;
                state_q                  <= WRITE;
            end else begin
                mem_we_q <= 1'b0;
                state_q  <= IDLE;
            end
        end
    end

`ifdef LOADER_BRIDGE_CHECKSUM_EN
    logic [15:0] checksum_q;

    assign checksum = checksum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) checksum_q <= '0;
        else if (pop) checksum_q <= checksum_q + 16'(fifo_q[rptr_q][DATA_W-1:0]);
    end
`endif
endmodule

// File: tb/tb_loader_sdram_write_bridge.sv
// tb_loader_sdram_write_bridge: directed checks of the loader write bridge.
module tb_loader_sdram_write_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_strobe = 1'b0;
    logic [21:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        slot_en = 1'b0;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [7:0]  mem_data;
    logic        busy;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;
`ifdef LOADER_BRIDGE_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    logic pend = 1'b0;
    logic [29:0] log_q [$];

    loader_sdram_write_bridge dut (
        .clk(clk), .reset(reset), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .slot_en(slot_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .level(level), .overflow(overflow),
`ifdef LOADER_BRIDGE_CHECKSUM_EN
        .checksum(checksum),
`endif
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Counts write-enable cycles and records each issued write the cycle after its slot.
    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (pend && mem_we) log_q.push_back({mem_addr, mem_data});
        pend = slot_en;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic w, input logic [21:0] a, input logic [7:0] d);
        slot_en = s;
        wr_strobe = w;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        slot_en = 1'b0;
        wr_strobe = 1'b0;
    endtask

    task automatic slots(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) step(1'b0, 1'b0, '0, '0);
            step(1'b1, 1'b0, '0, '0);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        step(1'b0, 1'b0, '0, '0);
        chk("rst_we", 64'(mem_we), 0);
        chk("rst_addr", 64'(mem_addr), 0);
        chk("rst_data", 64'(mem_data), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_level", 64'(level), 0);
        chk("rst_ovf", 64'(overflow), 0);
        chk("rst_drop", 64'(drop_count), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // single write
        step(1'b0, 1'b1, 22'h000010, 8'hA5);
        chk("t1_level", 64'(level), 1);
        chk("t1_busy", 64'(busy), 1);
        chk("t1_we_pre", 64'(mem_we), 0);
        we_cnt = 0;
        log_q.delete();
        step(1'b1, 1'b0, '0, '0);
        chk("t1_we", 64'(mem_we), 1);
        chk("t1_addr", 64'(mem_addr), 64'h10);
        chk("t1_data", 64'(mem_data), 64'hA5);
        slots(1);
        chk("t1_we_cnt", 64'(we_cnt), 4);
        chk("t1_we_post", 64'(mem_we), 0);
        chk("t1_busy_post", 64'(busy), 0);
        chk("t1_log_n", 64'(log_q.size()), 1);

        // two consecutive strobes
        step(1'b0, 1'b1, 22'h000100, 8'h11);
        step(1'b0, 1'b1, 22'h000101, 8'h22);
        we_cnt = 0;
        log_q.delete();
        slots(3);
        chk("t2_we_cnt", 64'(we_cnt), 8);
        chk("t2_log_n", 64'(log_q.size()), 2);
        if (log_q.size() == 2) begin
            chk("t2_first", 64'(log_q[0]), 64'({22'h100, 8'h11}));
            chk("t2_second", 64'(log_q[1]), 64'({22'h101, 8'h22}));
        end
        chk("t2_busy", 64'(busy), 0);

        // overflow burst
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 22'h200 + 22'(i), 8'h30 + 8'(i));
        chk("t3_level", 64'(level), 8);
        chk("t3_ovf", 64'(overflow), 1);
        chk("t3_drop", 64'(drop_count), 2);
        we_cnt = 0;
        log_q.delete();
        slots(9);
        chk("t3_we_cnt", 64'(we_cnt), 32);
        chk("t3_log_n", 64'(log_q.size()), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            chk("t3_order", 64'(log_q[i]), 64'({22'h200 + 22'(i), 8'h30 + 8'(i)}));
        chk("t3_level_post", 64'(level), 0);
        chk("t3_ovf_sticky", 64'(overflow), 1);

        // full FIFO with simultaneous push and pop
        pulse_reset();
        chk("t4_ovf_clr", 64'(overflow), 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 22'h300 + 22'(i), 8'h40 + 8'(i));
        chk("t4_full", 64'(level), 8);
        log_q.delete();
        step(1'b1, 1'b1, 22'h3FF, 8'h99);
        chk("t4_level", 64'(level), 8);
        chk("t4_ovf", 64'(overflow), 0);
        chk("t4_drop", 64'(drop_count), 0);
        chk("t4_head", 64'(mem_addr), 64'h300);
        slots(9);
        chk("t4_log_n", 64'(log_q.size()), 9);
        if (log_q.size() == 9) begin
            chk("t4_mid", 64'(log_q[7]), 64'({22'h307, 8'h47}));
            chk("t4_last", 64'(log_q[8]), 64'({22'h3FF, 8'h99}));
        end

        // asynchronous reset mid-operation
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 22'h400 + 22'(i), 8'h50 + 8'(i));
        step(1'b1, 1'b0, '0, '0);
        chk("t5_we_pre", 64'(mem_we), 1);
        chk("t5_level_pre", 64'(level), 5);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_we", 64'(mem_we), 0);
        chk("t5_level", 64'(level), 0);
        chk("t5_busy", 64'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        log_q.delete();
        we_cnt = 0;
        slots(3);
        chk("t5_no_writes", 64'(log_q.size()), 0);
        chk("t5_we_cnt", 64'(we_cnt), 0);

`ifdef LOADER_BRIDGE_CHECKSUM_EN
        step(1'b0, 1'b1, 22'h500, 8'hFF);
        step(1'b0, 1'b1, 22'h501, 8'h02);
        step(1'b0, 1'b1, 22'h502, 8'h80);
        slots(4);
        chk("t6_sum", 64'(checksum), 64'h0181);
        pulse_reset();
        chk("t6_sum_rst", 64'(checksum), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
